// File: rtl/tone_decoder.sv
// tone_decoder
//   Turns five band-pass comparator outputs into a confirmed direction command
//   for the drive state machine. Each comparator toggles at its tone frequency
//   when that tone is present. Rising edges are counted per channel over a
//   fixed window, and each channel is classified active or inactive. The
//   active set is decoded into a direction code, which must repeat over
//   several windows before the lock is asserted.
//
// Ports
//   clk    in   1  system clock (50 MHz)
//   rst    in   1  asynchronous active-high reset
//   bp1    in   1  STRAIGHT tone comparator (asynchronous)
//   bp2    in   1  LEFT tone comparator (asynchronous)
//   bp3    in   1  RIGHT tone comparator (asynchronous)
//   bp4    in   1  BACK tone comparator (asynchronous)
//   bp5    in   1  junction-marker tone comparator (asynchronous)
//   tdEn   out  1  high while a direction is locked
//   tdDir  out  2  locked direction: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK
//   tdNew  out  1  one-cycle pulse on the cycle tdEn rises
module tone_decoder #(
  parameter int WINDOW_CYCLES   = 500000,
  parameter int CNT_W           = 16,
  parameter int MIN_EDGES       = 8,
  parameter int MAX_EDGES       = 80,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int LOSS_WINDOWS    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdNew
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_EDGES);

  localparam int FSM_MAX = (CONFIRM_WINDOWS > LOSS_WINDOWS) ? CONFIRM_WINDOWS : LOSS_WINDOWS;
  localparam int FSM_W   = $clog2(FSM_MAX + 1);
  localparam logic [FSM_W-1:0] CONF_TARGET = FSM_W'(CONFIRM_WINDOWS);
  localparam logic [FSM_W-1:0] LOSS_TARGET = FSM_W'(LOSS_WINDOWS);
  localparam logic [FSM_W-1:0] FSM_ONE     = FSM_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAND   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Channel index 0..3 are the direction tones, index 4 is the junction marker.
  logic [4:0] bp_raw;
  logic [4:0] meta;
  logic [4:0] sync;
  logic [4:0] sync_prev;
  logic [4:0] edge_pulse;

  logic [WIN_W-1:0] win_cnt;
  logic             tick;
  logic             eval;

  logic [CNT_W-1:0] edge_cnt [5];
  logic [CNT_W-1:0] cnt_next [5];
  logic [4:0]       active;

  logic       valid;
  logic [1:0] code;

  state_t           state;
  logic [1:0]       cand_code;
  logic [FSM_W-1:0] conf_cnt;
  logic [FSM_W-1:0] loss_cnt;

  assign bp_raw     = {bp5, bp4, bp3, bp2, bp1};
  assign edge_pulse = sync & ~sync_prev;
  assign tick       = (win_cnt == WIN_LAST);

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= '0;
      sync      <= '0;
      sync_prev <= '0;
    end else begin
      meta      <= bp_raw;
      sync      <= meta;
      sync_prev <= sync;
    end
  end

  // Free-running measurement window; tick marks its last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (tick) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Saturating next count, including any edge arriving in the current cycle,
  // so an edge on the tick cycle is credited to the window that is closing.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = edge_cnt[i];
      if (edge_pulse[i] && (edge_cnt[i] != {CNT_W{1'b1}})) begin
        cnt_next[i] = edge_cnt[i] + 1'b1;
      end
    end
  end

  // Edge counters and per-window classification. Counts above MAX_CNT are
  // treated as comparator chatter rather than a real tone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        edge_cnt[i] <= '0;
      end
      active <= '0;
      eval   <= 1'b0;
    end else begin
      eval <= tick;
      for (int i = 0; i < 5; i++) begin
        if (tick) begin
          edge_cnt[i] <= '0;
          active[i]   <= (cnt_next[i] >= MIN_CNT) && (cnt_next[i] <= MAX_CNT);
        end else begin
          edge_cnt[i] <= cnt_next[i];
        end
      end
    end
  end

  // A window is a valid command only with the junction marker present and
  // exactly one direction tone active.
  always_comb begin
    valid = 1'b0;
    code  = 2'd0;
    if (active[4]) begin
      case (active[3:0])
        4'b0001: begin valid = 1'b1; code = 2'd0; end
        4'b0010: begin valid = 1'b1; code = 2'd1; end
        4'b0100: begin valid = 1'b1; code = 2'd2; end
        4'b1000: begin valid = 1'b1; code = 2'd3; end
        default: begin valid = 1'b0; code = 2'd0; end
      endcase
    end
  end

  // Confirmation FSM, advanced once per window on eval. While locked, a
  // different valid code only counts as loss; a new direction always needs a
  // full unlock and reconfirmation. tdDir changes only when a lock is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand_code <= 2'd0;
      conf_cnt  <= '0;
      loss_cnt  <= '0;
      tdEn      <= 1'b0;
      tdDir     <= 2'd0;
      tdNew     <= 1'b0;
    end else begin
      tdNew <= 1'b0;
      if (eval) begin
        case (state)
          IDLE: begin
            if (valid) begin
              cand_code <= code;
              conf_cnt  <= FSM_ONE;
              if (CONFIRM_WINDOWS == 1) begin
                state    <= LOCKED;
                tdEn     <= 1'b1;
                tdDir    <= code;
                tdNew    <= 1'b1;
                loss_cnt <= '0;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (!valid) begin
              state    <= IDLE;
              conf_cnt <= '0;
            end else if (code == cand_code) begin
              conf_cnt <= conf_cnt + FSM_ONE;
              if ((conf_cnt + FSM_ONE) == CONF_TARGET) begin
                state    <= LOCKED;
                tdEn     <= 1'b1;
                tdDir    <= cand_code;
                tdNew    <= 1'b1;
                loss_cnt <= '0;
              end
            end else begin
              cand_code <= code;
              conf_cnt  <= FSM_ONE;
            end
          end
          LOCKED: begin
            if (valid && (code == tdDir)) begin
              loss_cnt <= '0;
            end else if ((loss_cnt + FSM_ONE) == LOSS_TARGET) begin
              state    <= IDLE;
              tdEn     <= 1'b0;
              loss_cnt <= '0;
              conf_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + FSM_ONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Upstream stage of the drive state machine. Produces its junction-command inputs `tdEn` and `tdDir`.
- Consumes five digital band-pass comparator outputs `bp1`..`bp5`. Each toggles at its tone frequency when that tone is present.
- Counts rising edges per channel over a fixed measurement window and classifies each channel as active or inactive.
- Decodes the active set into a direction code and confirms it over several consecutive windows before asserting `tdEn`.

Parameters:
- `WINDOW_CYCLES`, 500000: clk cycles per measurement window (10 ms at 50 MHz).
- `CNT_W`, 16: edge-counter width. Counters saturate.
- `MIN_EDGES`, 8: minimum rising edges per window for a channel to be active.
- `MAX_EDGES`, 80: maximum rising edges per window for a channel to be active. Higher counts are treated as noise.
- `CONFIRM_WINDOWS`, 3: consecutive identical valid windows required to lock.
- `LOSS_WINDOWS`, 2: consecutive non-matching windows required to drop lock.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: reset, asynchronous, active-high.
- `bp1`, input, 1: STRAIGHT tone comparator (asynchronous).
- `bp2`, input, 1: LEFT tone comparator (asynchronous).
- `bp3`, input, 1: RIGHT tone comparator (asynchronous).
- `bp4`, input, 1: BACK tone comparator (asynchronous).
- `bp5`, input, 1: junction-marker tone comparator (asynchronous).
- `tdEn`, output, 1: high while a direction is locked.
- `tdDir`, output, 2: locked direction. 00 = STRAIGHT, 01 = LEFT, 10 = RIGHT, 11 = BACK.
- `tdNew`, output, 1: one-cycle pulse on the cycle `tdEn` rises.

Behaviour:
- Reset (async, `rst`=1):
  - All synchronisers, edge counters, window counter, FSM counters and active register clear to 0.
  - State = IDLE.
  - `tdEn`=0, `tdDir`=00, `tdNew`=0.
  - Reset mid-window discards that window. Counting restarts at 0 on the first clk after release.
- Input capture:
  - Each `bp` input passes through a 2-FF synchroniser, then a rising-edge detect (sync & ~prev).
  - Input-to-edge-pulse latency is 3 cycles.
- Edge counters:
  - Per channel, CNT_W bits.
  - Increment on edge pulse. Saturate at 2^CNT_W-1, no wrap.
- Window counter:
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - `tick` is asserted when the count equals WINDOW_CYCLES-1.
- On `tick`:
  - An edge pulse in the tick cycle belongs to the closing window.
  - `active[i]` is registered as MIN_EDGES <= count_i (+1 if edge this cycle) <= MAX_EDGES.
  - All edge counters clear to 0.
  - A registered one-cycle `eval` strobe fires the next cycle.
- Decode (combinational on the registered active vector):
  - `valid` = `active[5]` AND exactly one of `active[1..4]`.
  - `code` = index of that channel minus 1.
  - `valid`=0 if `bp5` is absent, if none of `bp1..bp4` is active, or if two or more are active.
- FSM, steps only on `eval`; outputs update on the same clk edge as the transition:
  - IDLE:
    - valid → `candCode`=`code`, `confCnt`=1. If CONFIRM_WINDOWS==1, go directly to LOCKED; otherwise go to CAND.
    - otherwise stay in IDLE.
  - CAND:
    - valid and `code`==`candCode` → `confCnt`+1. When it reaches CONFIRM_WINDOWS → LOCKED.
    - valid and `code`!=`candCode` → `candCode`=`code`, `confCnt`=1, stay in CAND.
    - not valid → IDLE.
  - Entering LOCKED:
    - `tdDir`=`candCode`, `tdEn`=1, `tdNew`=1 for exactly one cycle.
    - `lossCnt`=0.
  - LOCKED:
    - valid and `code`==`tdDir` → `lossCnt`=0.
    - otherwise (invalid, or valid with a different code) → `lossCnt`+1. When it reaches LOSS_WINDOWS → IDLE and `tdEn`=0.
    - There is no direct switch to a new code. A new command requires unlock followed by a fresh confirmation.
- Output holds:
  - `tdDir` holds its last locked value after unlock. It changes only when entering LOCKED.
  - `tdNew` is 0 at all other times.
- Latency: `tdEn` rises 2 clk cycles after the tick cycle of the CONFIRM_WINDOWS-th qualifying window.
- FSM counter widths are sized to hold max(CONFIRM_WINDOWS, LOSS_WINDOWS).

Test Plan:
All scenarios use WINDOW_CYCLES=1000, MIN_EDGES=8, MAX_EDGES=80, CONFIRM_WINDOWS=3, LOSS_WINDOWS=2.
1. Assert `rst` asynchronously mid-cycle with inputs toggling → `tdEn`=0, `tdDir`=00, `tdNew`=0 immediately. No lock for at least 3 windows after release.
2. `bp5` and `bp2` square waves with 40-cycle period (25 edges/window) for 4 windows → `tdEn`=1 and `tdDir`=01 two cycles after the third tick. `tdNew` high for exactly 1 cycle. `tdEn` stays high through window 4.
3. `bp5` plus `bp3` with 250-cycle period (4 edges) → never locks. `bp5` plus `bp3` toggling every cycle (500 edges) → never locks. `bp3` at 25 edges without `bp5` → never locks.
4. `bp5`, `bp1` and `bp4` all at 25 edges → invalid, no lock. Then two windows of `bp1`, then three windows of `bp4` → lock with `tdDir`=11 after the third `bp4` window.
5. Locked on RIGHT (10), then one silent window, then tone resumes → `tdEn` stays 1. Then two silent windows → `tdEn` falls 2 cycles after the second tick, and `tdDir` holds 10.
6. Locked on STRAIGHT, then switch to LEFT tones → `tdEn` drops after 2 windows and relocks to 01 after 3 further windows. Assert `rst` during LOCKED → immediate clear.
